// File: rtl/kernel_stream_bridge.sv
// Stream bridge for a fixed-latency, globally stalled kernel: joins two input
// streams, tracks token validity through the kernel and buffers results.
module kernel_stream_bridge #(
    parameter int unsigned DATAW      = 32,
    parameter int unsigned PIPE_LAT   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNTW       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNTW-1:0]  n_elems,
    output logic             done,
    output logic             busy,
    input  logic [DATAW-1:0] s0_data,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [DATAW-1:0] s1_data,
    input  logic             s1_valid,
    output logic             s1_ready,
    output logic [DATAW-1:0] k_vin0,
    output logic [DATAW-1:0] k_vin1,
    input  logic [DATAW-1:0] k_vout,
    output logic             stall,
    output logic [DATAW-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = PTRW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNTW-1:0]     n_q, n_d;
    logic [CNTW-1:0]     issued_q, issued_d;
    logic [CNTW-1:0]     retired_q, retired_d;
    logic [PIPE_LAT-1:0] vld_q, vld_d;
    logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [DATAW-1:0]    mem_q [FIFO_DEPTH];

    logic exit_vld;
    logic fifo_full;
    logic fifo_empty;
    logic fire;
    logic push;
    logic pop;

    // Handshake and stall decode, all from registered state plus stream inputs
    always_comb begin
        exit_vld   = vld_q[PIPE_LAT-1];
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        fifo_empty = (count_q == CW'(0));
        stall      = exit_vld & fifo_full;
        fire       = (state_q == S_RUN) & s0_valid & s1_valid & ~stall
                     & (issued_q < n_q);
        push       = exit_vld & ~stall;
        pop        = ~fifo_empty & m_ready;
    end

    assign s0_ready = fire;
    assign s1_ready = fire;
    assign k_vin0   = s0_data;
    assign k_vin1   = s1_data;
    assign m_valid  = ~fifo_empty;
    assign m_data   = mem_q[rd_ptr_q];
    assign busy     = (state_q == S_RUN) | (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);

    // Validity shadow of the kernel pipeline; frozen together with the kernel
    always_comb begin
        vld_d = vld_q;
        if (!stall) begin
            vld_d = (vld_q << 1) | PIPE_LAT'(fire);
        end
    end

    // Output buffer pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Run sequencer: DONE is entered in the cycle right after the final pop
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        issued_d  = issued_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d       = n_elems;
                    issued_d  = '0;
                    retired_d = '0;
                    state_d   = (n_elems == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (fire) begin
                    issued_d = issued_q + CNTW'(1);
                end
                if (pop) begin
                    retired_d = retired_q + CNTW'(1);
                end
                if (issued_q == n_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop) begin
                    retired_d = retired_q + CNTW'(1);
                end
                if (retired_d == n_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            issued_q  <= '0;
            retired_q <= '0;
            vld_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            issued_q  <= issued_d;
            retired_q <= retired_d;
            vld_q     <= vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Result storage needs no reset; occupancy alone defines what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= k_vout;
        end
    end

endmodule

// File: tb/tb_kernel_stream_bridge.sv
// Directed bench for kernel_stream_bridge with a behavioural two-stage kernel
// (stage 1: a+b, stage 2: +0x100) frozen by the bridge's stall.
module tb_kernel_stream_bridge;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] n_elems;
    logic        done;
    logic        busy;
    logic [31:0] s0_data;
    logic        s0_valid;
    logic        s0_ready;
    logic [31:0] s1_data;
    logic        s1_valid;
    logic        s1_ready;
    logic [31:0] k_vin0;
    logic [31:0] k_vin1;
    logic [31:0] k_vout;
    logic        stall;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    kernel_stream_bridge dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n_elems  (n_elems),
        .done     (done),
        .busy     (busy),
        .s0_data  (s0_data),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s1_data  (s1_data),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .k_vin0   (k_vin0),
        .k_vin1   (k_vin1),
        .k_vout   (k_vout),
        .stall    (stall),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] kr1;
    logic [31:0] kr2;
    always @(posedge clk) begin
        if (!stall) begin
            kr1 <= k_vin0 + k_vin1;
            kr2 <= kr1 + 32'h100;
        end
    end
    assign k_vout = kr2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [31:0] src_a [64];
    logic [31:0] src_b [64];
    logic [31:0] got [$];
    int  fires, first_fire, first_mv, last_pop, done_cyc;
    int  snap_fires, snap_got;
    logic snap_stall, snap_mv, snap_stall_next;
    bit  done_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] kern_ref(input logic [31:0] a, input logic [31:0] b);
        return a + b + 32'h100;
    endfunction

    task automatic fill_src(input int base);
        for (int i = 0; i < 64; i++) begin
            src_a[i] = 32'(base + i + 1);
            src_b[i] = 32'(10 * (i + 1));
        end
    endtask

    // One run: start pulse, then continuous supply from src_*; m_ready rises at
    // cycle rel; s1_valid withheld for hold1 cycles; stray start at start_cyc.
    task automatic run(input int n, input int rel, input int hold1,
                       input int start_cyc, input int budget);
        int idx;
        idx = 0;
        fires = 0; first_fire = -1; first_mv = -1; last_pop = -1; done_cyc = -1;
        done_seen = 0;
        got.delete();
        start = 1'b1; n_elems = 16'(n);
        s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
            s0_data  = src_a[idx];
            s1_data  = src_b[idx];
            s0_valid = 1'b1;
            s1_valid = (cyc >= hold1);
            m_ready  = (cyc >= rel);
            start    = (cyc == start_cyc);
            n_elems  = (cyc == start_cyc) ? 16'(n + 3) : 16'(n);
            @(negedge clk);
            if (cyc < hold1) check("join_no_ready", {30'd0, s0_ready, s1_ready}, 32'd0);
            if (hold1 > 0 && cyc == hold1) check("join_fire", {30'd0, s0_ready, s1_ready}, 32'd3);
            if (cyc == rel) begin
                snap_stall = stall; snap_mv = m_valid;
                snap_fires = fires; snap_got = got.size();
            end
            if (cyc == rel + 1) snap_stall_next = stall;
            if (s0_ready) begin
                fires++;
                if (first_fire < 0) first_fire = cyc;
                if (idx < 63) idx++;
            end
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                last_pop = cyc;
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
    endtask

    task automatic check_results(input string name, input int n);
        check({name, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            check({name, "_data"}, got[i], kern_ref(src_a[i], src_b[i]));
        end
    endtask

    initial begin
        vec_t tbl [8];
        tbl[0] = '{32'd1, 32'd10, 32'h10B};
        tbl[1] = '{32'd2, 32'd20, 32'h116};
        tbl[2] = '{32'd3, 32'd30, 32'h121};
        tbl[3] = '{32'd4, 32'd40, 32'h12C};
        tbl[4] = '{32'd5, 32'd50, 32'h137};
        tbl[5] = '{32'd6, 32'd60, 32'h142};
        tbl[6] = '{32'd7, 32'd70, 32'h14D};
        tbl[7] = '{32'd8, 32'd80, 32'h158};

        rst = 1'b1; start = 1'b0; n_elems = '0;
        s0_data = '0; s1_data = '0; s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_ready", {30'd0, s0_ready, s1_ready}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;

        // Streaming, driven from the vector table
        for (int i = 0; i < 8; i++) begin
            src_a[i] = tbl[i].a;
            src_b[i] = tbl[i].b;
        end
        run(8, 0, 0, -1, 60);
        check("stream_done_seen", {31'd0, done_seen}, 32'd1);
        check("stream_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("stream_data", (i < got.size()) ? got[i] : 32'hDEAD_BEEF, tbl[i].exp);
        end
        check("stream_first_fire", 32'(first_fire), 32'd0);
        check("stream_latency", 32'(first_mv - first_fire), 32'd3);
        check("stream_done_after_pop", 32'(done_cyc - last_pop), 32'd1);
        check("stream_fires", 32'(fires), 32'd8);
        @(negedge clk);
        check("stream_idle_busy", {31'd0, busy}, 32'd0);
        check("stream_idle_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;

        // Back-pressure, then full FIFO popped while a result waits at the exit
        fill_src(100);
        run(10, 15, 0, -1, 80);
        check("bp_fires_at_block", 32'(snap_fires), 32'd6);
        check("bp_no_pops_before", 32'(snap_got), 32'd0);
        check("bp_m_valid", {31'd0, snap_mv}, 32'd1);
        check("bp_stall_full_pop", {31'd0, snap_stall}, 32'd1);
        check("bp_stall_released", {31'd0, snap_stall_next}, 32'd0);
        check("bp_done_seen", {31'd0, done_seen}, 32'd1);
        check_results("bp", 10);

        // Join: s1 withheld for 5 cycles
        fill_src(200);
        run(2, 0, 5, -1, 40);
        check("join_first_fire", 32'(first_fire), 32'd5);
        check("join_done_seen", {31'd0, done_seen}, 32'd1);
        check_results("join", 2);

        // Zero-length run
        @(posedge clk); #1;
        start = 1'b1; n_elems = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("zero_done_clear", {31'd0, done}, 32'd0);
        @(posedge clk); #1;

        // start during RUN is ignored
        fill_src(300);
        run(5, 0, 0, 2, 40);
        check("restart_fires", 32'(fires), 32'd5);
        check("restart_done_seen", {31'd0, done_seen}, 32'd1);
        check_results("restart", 5);

        // Reset mid-DRAIN with three results queued
        fill_src(400);
        run(3, 1000, 0, -1, 10);
        @(negedge clk);
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        check("mid_m_valid_pre", {31'd0, m_valid}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        fill_src(500);
        run(2, 0, 0, -1, 40);
        check("post_rst_done_seen", {31'd0, done_seen}, 32'd1);
        check_results("post_rst", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
